// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the pipeline sequencing controller.
// Optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
package pipe_ctrl_pkg;

    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 16;
    localparam int REG_ZERO  = 0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Combinational load-use hazard and control-flow redirect detection for the
// instruction currently in ID.
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] ID_rs_i,
    input  logic [REG_W-1:0] ID_rt_i,
    input  logic             ID_branch_i,
    input  logic             ID_eq_i,
    input  logic             ID_jump_i,
    input  logic             EX_memread_i,
    input  logic [REG_W-1:0] EX_rt_i,
    output logic             load_use_o,
    output logic             redirect_o
);

    logic ex_rt_nonzero;
    logic ex_rt_match;

    // A load into $0 writes nothing, so it can never feed a dependent instruction.
    assign ex_rt_nonzero = (EX_rt_i != REG_W'(REG_ZERO));
    assign ex_rt_match   = (EX_rt_i == ID_rs_i) || (EX_rt_i == ID_rt_i);
    assign load_use_o    = EX_memread_i && ex_rt_nonzero && ex_rt_match;
    assign redirect_o    = (ID_branch_i && ID_eq_i) || ID_jump_i;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: memory-wait FSM, stall/bubble/flush priority
// and optional perf counters (enabled by defining PIPE_CTRL_PERF_EN).
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ID_rs_i,
    input  logic [REG_W-1:0] ID_rt_i,
    input  logic             ID_branch_i,
    input  logic             ID_eq_i,
    input  logic             ID_jump_i,
    input  logic             EX_memread_i,
    input  logic [REG_W-1:0] EX_rt_i,
    input  logic             MEM_memread_i,
    input  logic             MEM_memwrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e state_q, state_d;
    logic   mem_acc;
    logic   mem_stall;
    logic   load_use;
    logic   redirect;

    hazard_unit #(.REG_W(REG_W)) u_hazard (
        .ID_rs_i      (ID_rs_i),
        .ID_rt_i      (ID_rt_i),
        .ID_branch_i  (ID_branch_i),
        .ID_eq_i      (ID_eq_i),
        .ID_jump_i    (ID_jump_i),
        .EX_memread_i (EX_memread_i),
        .EX_rt_i      (EX_rt_i),
        .load_use_o   (load_use),
        .redirect_o   (redirect)
    );

    assign mem_acc = MEM_memread_i || MEM_memwrite_i;

    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        mem_stall  = 1'b0;
        case (state_q)
            ST_RUN: begin
                dmem_req_o = mem_acc;
                mem_stall  = mem_acc;
                if (mem_acc) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // The pipeline releases on the ack cycle itself, so the
                // following RUN cycle already sees the next MEM instruction.
                dmem_req_o = 1'b1;
                mem_stall  = !dmem_ack_i;
                if (dmem_ack_i) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        PC_write_o    = 1'b1;
        IFID_write_o  = 1'b1;
        IFID_flush_o  = 1'b0;
        IDEX_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (mem_stall) begin
            PC_write_o   = 1'b0;
            IFID_write_o = 1'b0;
            pipe_hold_o  = 1'b1;
        end else if (load_use) begin
            // Any redirect waits; the branch is re-evaluated after the bubble.
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
        end else if (redirect) begin
            IFID_flush_o = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((mem_stall || load_use) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (IFID_flush_o && (flush_cnt_q != '1))            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl plus hand sequences for the
// memory handshake, priority, reset abort and (with PIPE_CTRL_PERF_EN) counters.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_branch, id_eq, id_jump, ex_memread;
    logic        mem_memread, mem_memwrite, dmem_ack;
    logic        dmem_req, pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    logic [15:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ID_rs_i        (id_rs),
        .ID_rt_i        (id_rt),
        .ID_branch_i    (id_branch),
        .ID_eq_i        (id_eq),
        .ID_jump_i      (id_jump),
        .EX_memread_i   (ex_memread),
        .EX_rt_i        (ex_rt),
        .MEM_memread_i  (mem_memread),
        .MEM_memwrite_i (mem_memwrite),
        .dmem_ack_i     (dmem_ack),
        .dmem_req_o     (dmem_req),
        .PC_write_o     (pc_write),
        .IFID_write_o   (ifid_write),
        .IFID_flush_o   (ifid_flush),
        .IDEX_bubble_o  (idex_bubble),
        .pipe_hold_o    (pipe_hold),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, exrt;
        logic       br, eq, j, exmr;
        logic       pc, ifw, ifw_chk, fl, bub;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic br,
                          input logic eq, input logic j, input logic exmr,
                          input logic [4:0] exrt, input logic mr, input logic mw,
                          input logic ack);
        id_rs = rs; id_rt = rt; id_branch = br; id_eq = eq; id_jump = j;
        ex_memread = exmr; ex_rt = exrt;
        mem_memread = mr; mem_memwrite = mw; dmem_ack = ack;
    endtask

    task automatic check_ctrl(input string name, input logic pc, input logic ifw,
                              input logic fl, input logic bub, input logic hold,
                              input logic req);
        check({name, ".pc"},   {31'd0, pc_write},    {31'd0, pc});
        check({name, ".ifw"},  {31'd0, ifid_write},  {31'd0, ifw});
        check({name, ".fl"},   {31'd0, ifid_flush},  {31'd0, fl});
        check({name, ".bub"},  {31'd0, idex_bubble}, {31'd0, bub});
        check({name, ".hold"}, {31'd0, pipe_hold},   {31'd0, hold});
        check({name, ".req"},  {31'd0, dmem_req},    {31'd0, req});
    endtask

    initial begin
        int req_cycles;
        int hold_cycles;

        //                    rs     rt     exrt   br    eq    j     exmr  pc    ifw   chk   fl    bub
        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{5'd8,  5'd3,  5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{5'd3,  5'd8,  5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{5'd9,  5'd10, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{5'd8,  5'd8,  5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{5'd1,  5'd2,  5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{5'd1,  5'd2,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{5'd4,  5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{5'd8,  5'd0,  5'd8,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{5'd1,  5'd2,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_ctrl("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].br, vecs[i].eq, vecs[i].j,
                   vecs[i].exmr, vecs[i].exrt, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("vec%0d.pc", i),   {31'd0, pc_write},    {31'd0, vecs[i].pc});
            if (vecs[i].ifw_chk)
                check($sformatf("vec%0d.ifw", i), {31'd0, ifid_write}, {31'd0, vecs[i].ifw});
            check($sformatf("vec%0d.fl", i),   {31'd0, ifid_flush},  {31'd0, vecs[i].fl});
            check($sformatf("vec%0d.bub", i),  {31'd0, idex_bubble}, {31'd0, vecs[i].bub});
            check($sformatf("vec%0d.hold", i), {31'd0, pipe_hold},   32'd0);
            check($sformatf("vec%0d.req", i),  {31'd0, dmem_req},    32'd0);
            $display("vec %0d: rs=%0d rt=%0d exrt=%0d br=%b eq=%b j=%b exmr=%b -> pc=%b ifw=%b fl=%b bub=%b",
                     i, vecs[i].rs, vecs[i].rt, vecs[i].exrt, vecs[i].br, vecs[i].eq, vecs[i].j,
                     vecs[i].exmr, pc_write, ifid_write, ifid_flush, idex_bubble);
        end

        // Load-use then bubble in EX: normal on the next cycle.
        @(negedge clk); set_in(8, 3, 0, 0, 0, 1, 8, 0, 0, 0); #1;
        check_ctrl("lu1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); set_in(8, 3, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_ctrl("lu2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("seq load-use: one bubble cycle then normal");

        // sw with ack three cycles after request.
        req_cycles = 0;
        hold_cycles = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, (c == 3));
            #1;
            req_cycles  += int'(dmem_req);
            hold_cycles += int'(pipe_hold);
        end
        check("sw.release_pc", {31'd0, pc_write}, 32'd1);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_ctrl("sw.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("sw.req_cycles", req_cycles, 4);
        check("sw.hold_cycles", hold_cycles, 3);
        $display("seq sw: req=%0d cycles hold=%0d cycles", req_cycles, hold_cycles);

        // Stray ack in RUN: no effect, and a new access still stalls in RUN.
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        check_ctrl("stray", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); #1;
        check_ctrl("stray.run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); #1;
        check_ctrl("stray.wait", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check_ctrl("stray.idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("seq stray ack: ignored in RUN");

        // mem_stall + load_use + taken beq: hold only, then bubble, then flush.
        @(negedge clk); set_in(8, 2, 1, 1, 0, 1, 8, 1, 0, 0); #1;
        check_ctrl("prio.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); set_in(8, 2, 1, 1, 0, 1, 8, 1, 0, 1); #1;
        check_ctrl("prio.bubble", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk); set_in(8, 2, 1, 1, 0, 0, 0, 0, 0, 0); #1;
        check("prio.flush", {31'd0, ifid_flush}, 32'd1);
        check("prio.flush_pc", {31'd0, pc_write}, 32'd1);
        $display("seq priority: hold, then bubble, then flush");

        // Reset pulsed mid-WAIT aborts the access asynchronously.
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        check("rstw.run_req", {31'd0, dmem_req}, 32'd1);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        check("rstw.wait_req", {31'd0, dmem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstw.req_drop", {31'd0, dmem_req}, 32'd0);
        check("rstw.hold", {31'd0, pipe_hold}, 32'd0);
        check("rstw.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rstw.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
        check_ctrl("rstw.run_again", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
        check("rstw.release", {31'd0, pipe_hold}, 32'd0);
        $display("seq reset mid-WAIT: req dropped, state RUN");

        // Counter sequence: 3 load-use + 2 memory stall cycles, then 2 flushes.
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); set_in(8, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, (c == 2));
        end
        @(negedge clk); set_in(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
`ifdef PIPE_CTRL_PERF_EN
        check("perf.stall_cnt", {16'd0, stall_cnt}, 32'd5);
        check("perf.flush_cnt", {16'd0, flush_cnt}, 32'd2);
        $display("seq perf: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
        set_in(8, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        repeat (65540) @(negedge clk);
        #1;
        check("perf.stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check("perf.flush_hold", {16'd0, flush_cnt}, 32'd2);
        $display("seq perf saturation: stall_cnt=%0h", stall_cnt);
`else
        check("noperf.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("noperf.flush_cnt", {16'd0, flush_cnt}, 32'd0);
        $display("seq counters disabled: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
